sram_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the board's 1M x 16 async SRAM (SRAM_* pins).

---
 rtl/sram_arbiter_if.sv | 20 ++
 rtl/sram_arbiter.sv | 83 ++++++++
 tb/tb_sram_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response bundle for the two user ports of sram_arbiter
interface sram_arbiter_if;
  logic        a_req, a_we, a_ack, a_rvalid;
  logic [19:0] a_addr;
  logic [15:0] a_wdata;
  logic [1:0]  a_be;
  logic        b_req, b_we, b_ack, b_rvalid;
  logic [19:0] b_addr;
  logic [15:0] b_wdata;
  logic [1:0]  b_be;
  logic [15:0] rdata;
  modport master (
    output a_req, a_we, a_addr, a_wdata, a_be, b_req, b_we, b_addr, b_wdata, b_be,
    input  a_ack, a_rvalid, b_ack, b_rvalid, rdata
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_be, b_req, b_we, b_addr, b_wdata, b_be,
    output a_ack, a_rvalid, b_ack, b_rvalid, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port sequencer for a 1M x 16 async SRAM with registered pins
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic          CLOCK_50,
  input  logic          RST_N,
  sram_arbiter_if.slave bus,
  output logic [19:0]   SRAM_ADDR,
  inout  wire  [15:0]   SRAM_DQ,
  output logic          SRAM_CE_N,
  output logic          SRAM_OE_N,
  output logic          SRAM_WE_N,
  output logic          SRAM_LB_N,
  output logic          SRAM_UB_N
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES);
  typedef enum logic [1:0] {IDLE, ACC, TURN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic gnt_a, gnt_b, last_acc, owner, op_we, dq_oe;
  logic [1:0] op_be;
  logic [15:0] dq_out;
  logic nx_owner, nx_we, acc_n, ce_nx, oe_nx, wr_nx, lb_nx, ub_nx, dq_oe_nx;
  logic [1:0] nx_be;
  logic [19:0] nx_addr;
  logic [15:0] nx_wdata;
  assign SRAM_DQ = dq_oe ? dq_out : 'z;
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 1'b1;
      op_we <= 1'b0;
      op_be <= 2'b00;
      SRAM_ADDR <= '0;
      dq_out <= '0;
      dq_oe <= 1'b0;
      {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N} <= 5'b11111;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      owner <= nx_owner;
      op_we <= nx_we;
      op_be <= nx_be;
      SRAM_ADDR <= nx_addr;
      dq_out <= nx_wdata;
      dq_oe <= dq_oe_nx;
      {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N} <= {ce_nx, oe_nx, wr_nx, lb_nx, ub_nx};
      bus.a_rvalid <= last_acc && !op_we && !owner;
      bus.b_rvalid <= last_acc && !op_we && owner;
      // disabled byte lanes read back as zero regardless of what the bus carries
      bus.rdata <= (last_acc && !op_we) ? SRAM_DQ & {{8{op_be[1]}}, {8{op_be[0]}}} : bus.rdata;
    end
  end
  always_comb begin
    gnt_a = RST_N && state == IDLE && bus.a_req && (!bus.b_req || owner);
    gnt_b = RST_N && state == IDLE && bus.b_req && !gnt_a;
    last_acc = state == ACC && cnt == LAST;
    state_n = (gnt_a || gnt_b) ? ACC : last_acc ? (op_we ? TURN : IDLE) : state == TURN ? IDLE : state;
    cnt_n = state_n != ACC ? '0 : state == ACC ? cnt + 1'b1 : CW'(1);
  end
  always_comb begin
    nx_owner = gnt_b ? 1'b1 : gnt_a ? 1'b0 : owner;
    nx_we = gnt_a ? bus.a_we : gnt_b ? bus.b_we : op_we;
    nx_be = gnt_a ? bus.a_be : gnt_b ? bus.b_be : op_be;
    nx_addr = gnt_a ? bus.a_addr : gnt_b ? bus.b_addr : SRAM_ADDR;
    nx_wdata = gnt_a ? bus.a_wdata : gnt_b ? bus.b_wdata : dq_out;
    acc_n = state_n == ACC;
    ce_nx = !acc_n;
    oe_nx = !(acc_n && !nx_we);
    // WE rises one cycle before CE so address and data hold past the write edge
    wr_nx = !(acc_n && nx_we && cnt_n != LAST);
    lb_nx = !(acc_n && nx_be[0]);
    ub_nx = !(acc_n && nx_be[1]);
    dq_oe_nx = acc_n && nx_we;
  end
  assign bus.a_ack = gnt_a;
  assign bus.b_ack = gnt_b;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a per-cycle timeline model
module tb_sram_arbiter;
  localparam int AC = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #10 clk = ~clk;
  sram_arbiter_if bus();
  wire  [15:0] dq;
  logic [19:0] addr;
  logic ce_n, oe_n, we_n, lb_n, ub_n;
  sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .CLOCK_50(clk), .RST_N(rst_n), .bus(bus.slave), .SRAM_ADDR(addr), .SRAM_DQ(dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );
  logic [15:0] mem [0:(1<<20)-1];
  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'hzzzz;
  always @(posedge clk)
    if (rst_n && !ce_n && !we_n) begin
      if (!lb_n) mem[addr][7:0] <= dq[7:0];
      if (!ub_n) mem[addr][15:8] <= dq[15:8];
    end
  int n_tests = 0, n_fail = 0, cyc = 0, free_at = 0, acc_t = -100, na = 0, nb = 0, la = 0, lb = 0;
  bit last_b = 1'b1, acc_we = 1'b0, seen_a = 1'b0, seen_b = 1'b0;
  logic [19:0] acc_addr = '0;
  logic [15:0] acc_wd = '0;
  logic [1:0]  acc_be = '0;
  logic [15:0] ref_mem [logic [19:0]];
  typedef struct {int t; bit pb; logic [15:0] d;} rd_t;
  rd_t rq[$];
  logic [19:0] pool [8] = '{20'h00000, 20'h00010, 20'hFFFFF, 20'h12345, 20'h80000, 20'h7FFFF, 20'h00001, 20'hABCDE};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [15:0] lanes(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction
  function automatic logic [15:0] peek(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction
  always @(negedge clk) begin
    int k;
    bit act, ea, eb, w;
    logic [1:0] erv, be;
    logic [19:0] a;
    logic [15:0] d;
    cyc++;
    k = cyc - acc_t;
    act = k >= 1 && k <= AC;
    chk("pins", {ce_n, oe_n, we_n, lb_n, ub_n},
        act ? {1'b0, acc_we, !(acc_we && k < AC), !acc_be[0], !acc_be[1]} : 5'b11111);
    if (act) chk("addr", addr, acc_addr);
    if (act && acc_we) chk("dq_write", dq, acc_wd);
    erv = (rq.size() > 0 && rq[0].t == cyc) ? (rq[0].pb ? 2'b01 : 2'b10) : 2'b00;
    chk("rvalid", {bus.a_rvalid, bus.b_rvalid}, erv);
    if (erv != 2'b00) begin
      chk("rdata", bus.rdata, rq[0].d);
      void'(rq.pop_front());
    end
    ea = rst_n && cyc >= free_at && bus.a_req && (!bus.b_req || last_b);
    eb = rst_n && cyc >= free_at && bus.b_req && !ea;
    chk("ack", {bus.a_ack, bus.b_ack}, {ea, eb});
    seen_a = bus.a_ack;
    seen_b = bus.b_ack;
    if (bus.a_ack) begin na++; la = cyc; end
    if (bus.b_ack) begin nb++; lb = cyc; end
    if (ea || eb) begin
      w = eb ? bus.b_we : bus.a_we;
      a = eb ? bus.b_addr : bus.a_addr;
      d = eb ? bus.b_wdata : bus.a_wdata;
      be = eb ? bus.b_be : bus.a_be;
      acc_t = cyc; acc_we = w; acc_addr = a; acc_wd = d; acc_be = be; last_b = eb;
      free_at = cyc + AC + (w ? 2 : 1);
      if (w) ref_mem[a] = peek(a) & ~lanes(be) | d & lanes(be);
      else rq.push_back(rd_t'{cyc + AC + 1, eb, peek(a) & lanes(be)});
    end
    if (!rst_n) begin
      acc_t = -100;
      rq.delete();
      last_b = 1'b1;
      free_at = cyc + 1;
    end
  end
  task automatic drive(input bit pb, input bit we, input logic [19:0] a, input logic [15:0] d,
                       input logic [1:0] be, input bit req);
    if (pb) begin bus.b_we = we; bus.b_addr = a; bus.b_wdata = d; bus.b_be = be; bus.b_req = req; end
    else begin bus.a_we = we; bus.a_addr = a; bus.a_wdata = d; bus.a_be = be; bus.a_req = req; end
  endtask
  task automatic wait_ack(input bit pb);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!(pb ? seen_b : seen_a) && n < 20);
    chk(pb ? "ack_wait_b" : "ack_wait_a", n < 20, 1'b1);
    if (pb) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask
  task automatic issue(input bit pb, input bit we, input logic [19:0] a, input logic [15:0] d,
                       input logic [1:0] be);
    @(posedge clk); #1;
    drive(pb, we, a, d, be, 1'b1);
    wait_ack(pb);
  endtask
  task automatic rnd(input bit pb);
    drive(pb, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom), 2'($urandom),
          $urandom_range(0, 3) != 0);
  endtask
  initial begin
    int a0, b0;
    drive(0, 0, '0, '0, '0, 0);
    drive(1, 0, '0, '0, '0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 16'h0000);
    chk("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
    rst_n = 1'b1;
    issue(0, 1, 20'h00010, 16'hBEEF, 2'b11);
    issue(0, 0, 20'h00010, 16'h0000, 2'b11);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_rdata", bus.rdata, 16'hBEEF);
    issue(0, 1, 20'hFFFFF, 16'hFFFF, 2'b11);
    issue(0, 1, 20'hFFFFF, 16'h1234, 2'b01);
    issue(0, 0, 20'hFFFFF, 16'h0000, 2'b11);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_rdata", bus.rdata, 16'hFF34);
    repeat (4) @(posedge clk);
    #1;
    a0 = na; b0 = nb;
    drive(0, 0, 20'h00010, 16'h0, 2'b11, 1);
    drive(1, 0, 20'hFFFFF, 16'h0, 2'b11, 1);
    repeat (12) @(posedge clk);
    #1;
    drive(0, 0, 20'h00010, 16'h0, 2'b11, 0);
    drive(1, 0, 20'hFFFFF, 16'h0, 2'b11, 0);
    chk("t2_a_grants", na - a0, 2);
    chk("t2_b_grants", nb - b0, 2);
    repeat (4) @(posedge clk);
    issue(0, 1, 20'h00010, 16'hC0DE, 2'b11);
    issue(1, 0, 20'h00010, 16'h0000, 2'b11);
    chk("t4_gap", lb - la, 4);
    repeat (4) @(posedge clk);
    issue(0, 1, 20'h55555, 16'hDEAD, 2'b11);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 20'h00010, 16'h0, 2'b11, 1);
    drive(1, 0, 20'hFFFFF, 16'h0, 2'b11, 1);
    @(negedge clk);
    chk("t5_tie", {bus.a_ack, bus.b_ack}, 2'b10);
    @(posedge clk); #1;
    bus.a_req = 1'b0;
    wait_ack(1);
    repeat (4) @(posedge clk);
    issue(0, 0, 20'h00010, 16'h0000, 2'b11);
    b0 = nb;
    drive(1, 0, 20'h00010, 16'h0, 2'b11, 1);
    @(posedge clk); #1;
    bus.b_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_no_b_ack", nb - b0, 0);
    foreach (pool[i]) issue(0, 1, pool[i], 16'($urandom), 2'b11);
    repeat (1500) begin
      @(posedge clk); #1;
      if (seen_a || !bus.a_req) rnd(0);
      else if ($urandom_range(0, 19) == 0) bus.a_req = 1'b0;
      if (seen_b || !bus.b_req) rnd(1);
      else if ($urandom_range(0, 19) == 0) bus.b_req = 1'b0;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("drain", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
